// File: rtl/irq_controller.sv
// irq_controller: seven-source interrupt controller with edge-detected pending
// bits, a source mask, fixed-priority selection (highest index wins) and a
// three-state handshake (IDLE -> REQ -> SVC) with the program counter stage.
// Optional feature: define IRQCTL_SYNC_EN to put a 2-flop synchroniser on src_i.
module irq_controller #(
  parameter logic [6:0] MASK_RST = 7'h7F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] src_i,
  input  logic       mask_we_i,
  input  logic [6:0] mask_wdata_i,
  input  logic       ack_i,
  input  logic       eirq_i,
  output logic       irq1_o,
  output logic       irq2_o,
  output logic       irq3_o,
  output logic [6:0] pending_o,
  output logic [2:0] isr_code_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } state_t;

  state_t     state_q;
  logic [6:0] s_s;
  logic [6:0] s_d_q;
  logic [6:0] edge_s;
  logic [6:0] pending_q, pending_d;
  logic [6:0] mask_q, mask_d;
  logic [6:0] req_vec_s;
  logic [6:0] clr_s;
  logic [2:0] sel_code_s;
  logic [2:0] irq_q;
  logic [2:0] isr_q;
  logic       busy_q;

`ifdef IRQCTL_SYNC_EN
  logic [6:0] sync1_q;
  logic [6:0] sync2_q;

  // Two-flop synchroniser bringing the asynchronous sources into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 7'd0;
      sync2_q <= 7'd0;
    end else begin
      sync1_q <= src_i;
      sync2_q <= sync1_q;
    end
  end

  assign s_s = sync2_q;
`else
  assign s_s = src_i;
`endif

  // Edge detect, priority select, and next values for pending and mask.
  always_comb begin
    edge_s     = s_s & ~s_d_q;
    req_vec_s  = pending_q & mask_q;
    sel_code_s = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (req_vec_s[i]) begin
        sel_code_s = 3'(i + 1);
      end else begin
        sel_code_s = sel_code_s;
      end
    end
    // The served bit is cleared on ack; a coincident new edge re-sets it.
    if ((state_q == ST_REQ) && ack_i) begin
      clr_s = 7'b000_0001 << (irq_q - 3'd1);
    end else begin
      clr_s = 7'd0;
    end
    pending_d = (pending_q & ~clr_s) | edge_s;
    if (mask_we_i) begin
      mask_d = mask_wdata_i;
    end else begin
      mask_d = mask_q;
    end
  end

  // Source history, pending and mask registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_d_q     <= 7'd0;
      pending_q <= 7'd0;
      mask_q    <= MASK_RST;
    end else begin
      s_d_q     <= s_s;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  // Request/service handshake FSM; vector code, isr code and busy are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      irq_q   <= 3'd0;
      isr_q   <= 3'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_vec_s != 7'd0) begin
            state_q <= ST_REQ;
            irq_q   <= sel_code_s;
            busy_q  <= 1'b1;
          end
        end
        ST_REQ: begin
          // Code is frozen here until the PC stage takes it.
          if (ack_i) begin
            state_q <= ST_SVC;
            isr_q   <= irq_q;
            irq_q   <= 3'd0;
          end
        end
        ST_SVC: begin
          if (eirq_i) begin
            state_q <= ST_IDLE;
            isr_q   <= 3'd0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          irq_q   <= 3'd0;
          isr_q   <= 3'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign irq1_o     = irq_q[0];
  assign irq2_o     = irq_q[1];
  assign irq3_o     = irq_q[2];
  assign pending_o  = pending_q;
  assign isr_code_o = isr_q;
  assign busy_o     = busy_q;

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter MASK_RST, default 7'h7F, SHALL set the mask register reset value (bit=1 enables the source).
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 src  input  7  asynchronous interrupt sources; src[i] maps to vector code i+1.
REQ-005 mask_we  input  1  single-cycle mask register write strobe.
REQ-006 mask_wdata  input  7  new mask value, written when mask_we=1.
REQ-007 ack  input  1  single-cycle pulse from the program counter stage: the request has been taken and the return address pushed.
REQ-008 eirq  input  1  single-cycle end-of-interrupt pulse from the program counter stage (outer RET).
REQ-009 irq1, irq2, irq3  output  1 each  registered vector code {irq3,irq2,irq1}, 1..7; 0 = no request.
REQ-010 pending  output  7  current pending register.
REQ-011 isr_code  output  3  code of the interrupt in service; 0 when none.
REQ-012 busy  output  1  high in REQ and SVC states.

Function
REQ-013 Edge detection SHALL use s (src after optional synchroniser) and registered copy s_d; edge[i] = s[i] & ~s_d[i].
REQ-014 pending[i] SHALL set on the clock edge where edge[i]=1; levels held high SHALL NOT re-trigger.
REQ-015 Masked sources SHALL still set pending; the mask SHALL gate request selection only.
REQ-016 Selection SHALL be fixed priority, highest index of (pending & mask) wins.
REQ-017 FSM states: IDLE, REQ, SVC; reset state IDLE.
REQ-018 IDLE->REQ SHALL occur on the clock edge where (pending & mask)!=0; the selected code SHALL be registered onto irq3..irq1 at that same edge.
REQ-019 In REQ, the code SHALL stay stable regardless of new pendings, higher priorities or mask writes, until ack.
REQ-020 REQ->SVC on ack: clear pending[code-1], load isr_code=code, drive irq3..irq1=0 from the next cycle.
REQ-021 If edge on the source being cleared coincides with ack, set SHALL win; the pending bit SHALL remain 1.
REQ-022 SVC->IDLE on eirq: isr_code SHALL go to 0. If pending & mask is nonzero, REQ SHALL be entered one cycle later; there is no nesting.
REQ-023 ack outside REQ and eirq outside SVC SHALL be ignored.
REQ-024 A mask write SHALL take effect for selection on the cycle after mask_we.
REQ-025 irq3..irq1 SHALL be nonzero only in REQ.

Reset
REQ-026 rst SHALL immediately set state=IDLE, pending=0, isr_code=0, irq1..3=0, busy=0, mask=MASK_RST, s_d=0, synchroniser flops=0.
REQ-027 Reset during REQ or SVC SHALL discard the request and all pending events.

Configuration
REQ-028 Macro IRQCTL_SYNC_EN defined: src SHALL pass a 2-flop synchroniser; src rising before edge N sets pending at edge N+2.
REQ-029 Macro IRQCTL_SYNC_EN undefined: s=src directly; src rising before edge N sets pending at edge N.

Verification
REQ-030 SYNC_EN defined, src=7'h04 rising before edge 0 -> pending=7'h04 after edge 2; {irq3,irq2,irq1}=3 after edge 3; busy=1.
REQ-031 src bits 0 and 6 rise together -> code 7 requested; ack -> isr_code=7, pending=7'h01; eirq -> code 1 requested one cycle later.
REQ-032 mask=7'h7E, src[0] rises -> pending=7'h01, irq outputs remain 0; write mask=7'h7F -> code 1 appears 2 cycles after mask_we.
REQ-033 In REQ with code 2, new edge on src[1] in the ack cycle -> after ack, pending[1]=1 and isr_code=2.
REQ-034 ack in IDLE and eirq in REQ -> no state change; rst asserted in SVC -> all outputs 0, mask=MASK_RST within the same cycle.
